// File: rtl/merger_tree_lw.sv
// merger_tree_lw: L-leaf binary merge tree. Each leaf streams sorted runs of
// records terminated by an all-zero record; the root emits the merged runs,
// one terminal per run, through a registered write port.

// One 2-to-1 merge node: picks the smaller head, terminals rank above data.
module merger_tree_lw_node #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         a_empty,
    input  logic         b_empty,
    input  logic         out_ok,
    output logic         fire,
    output logic         pop_a,
    output logic         pop_b,
    output logic [W-1:0] rec
);
    logic a_term;
    logic b_term;
    logic both_term;
    logic take_a;

    assign a_term    = (a == '0);
    assign b_term    = (b == '0);
    assign both_term = a_term && b_term;

    // Choose the input to emit; ties and the double-terminal case go to A.
    always_comb begin
        take_a = 1'b0;
        if (b_term)
            take_a = 1'b1;
        else if (a_term)
            take_a = 1'b0;
        else
            take_a = (a <= b);
    end

    assign fire  = !a_empty && !b_empty && out_ok;
    assign pop_a = fire && (take_a || both_term);
    assign pop_b = fire && (!take_a || both_term);
    assign rec   = take_a ? a : b;
endmodule

// Inter-level FIFO: head visible the cycle after a push; push+pop while full is legal.
module merger_tree_lw_fifo #(
    parameter int W = 32,
    parameter int D = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);
    localparam int AW = (D > 1) ? $clog2(D) : 1;

    logic [W-1:0] mem [D];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Storage write; when full, the slot written is the one being popped this cycle.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    // Pointer update; reset empties the FIFO and discards its contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

module merger_tree_lw #(
    parameter int L = 4,
    parameter int W = 32,
    parameter int D = 2
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [W*L-1:0] i_fifo,
    input  logic [L-1:0]   i_fifo_empty,
    input  logic           i_fifo_out_ready,
    output logic [L-1:0]   o_fifo_read,
    output logic           o_out_fifo_write,
    output logic [W-1:0]   o_data,
    output logic [31:0]    o_rec_count,
    output logic [15:0]    o_run_count
);
    // Nodes are numbered heap style: 1 is the root, children of n are 2n and 2n+1.
    // Nodes n >= L/2 read leaves 2n-L and 2n-L+1. Node n>1 owns FIFO n.
    logic [W-1:0] n_a       [1:L-1];
    logic [W-1:0] n_b       [1:L-1];
    logic [W-1:0] n_rec     [1:L-1];
    logic         n_a_empty [1:L-1];
    logic         n_b_empty [1:L-1];
    logic         n_ok      [1:L-1];
    logic         n_fire    [1:L-1];
    logic         n_pop_a   [1:L-1];
    logic         n_pop_b   [1:L-1];

    logic [W-1:0] f_head    [1:L-1];
    logic         f_empty   [1:L-1];
    logic         f_full    [1:L-1];
    logic         f_pop     [1:L-1];

    for (genvar n = 1; n < L; n++) begin : g_node
        merger_tree_lw_node #(.W(W)) u_node (
            .a       (n_a[n]),
            .b       (n_b[n]),
            .a_empty (n_a_empty[n]),
            .b_empty (n_b_empty[n]),
            .out_ok  (n_ok[n]),
            .fire    (n_fire[n]),
            .pop_a   (n_pop_a[n]),
            .pop_b   (n_pop_b[n]),
            .rec     (n_rec[n])
        );

        if (n >= L/2) begin : g_leaf
            localparam int KA = 2*n - L;
            localparam int KB = 2*n - L + 1;
            assign n_a[n]         = i_fifo[W*KA +: W];
            assign n_b[n]         = i_fifo[W*KB +: W];
            assign n_a_empty[n]   = i_fifo_empty[KA];
            assign n_b_empty[n]   = i_fifo_empty[KB];
            assign o_fifo_read[KA] = n_pop_a[n];
            assign o_fifo_read[KB] = n_pop_b[n];
        end else begin : g_inner
            assign n_a[n]       = f_head[2*n];
            assign n_b[n]       = f_head[2*n+1];
            assign n_a_empty[n] = f_empty[2*n];
            assign n_b_empty[n] = f_empty[2*n+1];
            assign f_pop[2*n]   = n_pop_a[n];
            assign f_pop[2*n+1] = n_pop_b[n];
        end

        if (n == 1) begin : g_root
            // Root has no FIFO; it is throttled only by downstream ready.
            assign n_ok[n]    = i_fifo_out_ready && !i_rst;
            assign f_head[n]  = '0;
            assign f_empty[n] = 1'b1;
            assign f_full[n]  = 1'b0;
            assign f_pop[n]   = 1'b0;
        end else begin : g_fifo
            // A full FIFO still accepts when its parent drains it this cycle.
            assign n_ok[n] = (!f_full[n] || f_pop[n]) && !i_rst;
            merger_tree_lw_fifo #(.W(W), .D(D)) u_fifo (
                .clk   (i_clk),
                .rst   (i_rst),
                .push  (n_fire[n]),
                .pop   (f_pop[n]),
                .din   (n_rec[n]),
                .head  (f_head[n]),
                .empty (f_empty[n]),
                .full  (f_full[n])
            );
        end
    end

    // Register the root output and count records/terminals as they are emitted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_out_fifo_write <= 1'b0;
            o_data           <= '0;
            o_rec_count      <= '0;
            o_run_count      <= '0;
        end else begin
            o_out_fifo_write <= n_fire[1];
            if (n_fire[1]) begin
                o_data <= n_rec[1];
                if (n_rec[1] == '0)
                    o_run_count <= o_run_count + 16'd1;
                else
                    o_rec_count <= o_rec_count + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_merger_tree_lw.sv
// tb_merger_tree_lw: directed checks of merger_tree_lw at L=4, L=2 and L=16/W=8.
module tb_merger_tree_lw;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // L=4, W=32
    logic         rst4, ready4, wr4;
    logic [127:0] fifo4;
    logic [3:0]   emp4, rd4, mask4;
    logic [31:0]  data4, rec4;
    logic [15:0]  run4;
    // L=2, W=32
    logic         rst2, ready2, wr2;
    logic [63:0]  fifo2;
    logic [1:0]   emp2, rd2;
    logic [31:0]  data2, rec2;
    logic [15:0]  run2;
    // L=16, W=8
    logic         rst16, ready16, wr16;
    logic [127:0] fifo16;
    logic [15:0]  emp16, rd16, mask16;
    logic [7:0]   data16;
    logic [31:0]  rec16;
    logic [15:0]  run16;

    merger_tree_lw #(.L(4), .W(32), .D(2)) u_dut4 (
        .i_clk(clk), .i_rst(rst4), .i_fifo(fifo4), .i_fifo_empty(emp4),
        .i_fifo_out_ready(ready4), .o_fifo_read(rd4), .o_out_fifo_write(wr4),
        .o_data(data4), .o_rec_count(rec4), .o_run_count(run4));
    merger_tree_lw #(.L(2), .W(32), .D(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst2), .i_fifo(fifo2), .i_fifo_empty(emp2),
        .i_fifo_out_ready(ready2), .o_fifo_read(rd2), .o_out_fifo_write(wr2),
        .o_data(data2), .o_rec_count(rec2), .o_run_count(run2));
    merger_tree_lw #(.L(16), .W(8), .D(2)) u_dut16 (
        .i_clk(clk), .i_rst(rst16), .i_fifo(fifo16), .i_fifo_empty(emp16),
        .i_fifo_out_ready(ready16), .o_fifo_read(rd16), .o_out_fifo_write(wr16),
        .o_data(data16), .o_rec_count(rec16), .o_run_count(run16));

    // leaf FIFO models and output collectors
    int unsigned q4[4][$];
    int unsigned q2[2][$];
    int unsigned q16[16][$];
    int unsigned out4[$], out2[$], out16[$], exp_q[$], exp16[$];
    logic [1:0]  h2[$];
    int          pc4[4];
    logic [3:0]  last_rd4;
    int          viol = 0;
    int          n2_wr = 0;
    bit          term2 = 1'b0;
    bit          rnd16 = 1'b0;

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            emp4[k] = (q4[k].size() == 0) || mask4[k];
            fifo4[32*k +: 32] = (q4[k].size() != 0) ? q4[k][0] : 32'd0;
        end
        for (int k = 0; k < 2; k++) begin
            emp2[k] = term2 ? 1'b0 : (q2[k].size() == 0);
            fifo2[32*k +: 32] = (!term2 && q2[k].size() != 0) ? q2[k][0] : 32'd0;
        end
        for (int k = 0; k < 16; k++) begin
            emp16[k] = (q16[k].size() == 0) || mask16[k];
            fifo16[8*k +: 8] = (q16[k].size() != 0) ? 8'(q16[k][0]) : 8'd0;
        end
    endtask

    // One clock: sample pops before the edge, apply them and collect outputs after it.
    task automatic step();
        logic [3:0]  r4;
        logic [1:0]  r2;
        logic [15:0] r16;
        @(negedge clk);
        r4 = rd4; r2 = rd2; r16 = rd16;
        last_rd4 = r4;
        if ((r4 & emp4) != 0 || (r2 & emp2) != 0 || (r16 & emp16) != 0) viol++;
        if (!term2 && r2 != 0) h2.push_back(r2);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++)
            if (r4[k] && q4[k].size() > 0) begin q4[k].pop_front(); pc4[k]++; end
        for (int k = 0; k < 2; k++)
            if (!term2 && r2[k] && q2[k].size() > 0) q2[k].pop_front();
        for (int k = 0; k < 16; k++)
            if (r16[k] && q16[k].size() > 0) q16[k].pop_front();
        if (wr4) out4.push_back(data4);
        if (wr2) begin out2.push_back(data2); n2_wr++; end
        if (wr16) out16.push_back(32'(data16));
        if (rnd16) begin
            ready16 = ($urandom_range(3) != 0);
            mask16  = 16'($urandom & $urandom & $urandom);
        end
        drive();
    endtask

    task automatic chk_seq(input string tag, input int unsigned got[$], input int unsigned e[$]);
        int nb = 0;
        chk({tag, "_len"}, got.size(), e.size());
        for (int i = 0; i < e.size(); i++)
            if (i >= got.size() || got[i] != e[i]) nb++;
        chk({tag, "_mism"}, nb, 0);
    endtask

    task automatic reset4();
        rst4 = 1'b1; drive(); step();
        rst4 = 1'b0; drive();
        out4.delete();
        for (int k = 0; k < 4; k++) pc4[k] = 0;
    endtask

    task automatic load_long4();
        for (int k = 0; k < 4; k++) begin
            q4[k].delete();
            for (int j = 0; j < 10; j++) q4[k].push_back(k + 1 + 4*j);
            q4[k].push_back(0);
        end
        exp_q.delete();
        for (int i = 1; i <= 40; i++) exp_q.push_back(i);
        exp_q.push_back(0);
    endtask

    task automatic drain4(input int n);
        for (int c = 0; c < 300 && out4.size() < n; c++) step();
    endtask

    initial begin
        int first;
        int nvals;
        int unsigned rb[$];
        rst4 = 1'b1; rst2 = 1'b1; rst16 = 1'b1;
        ready4 = 1'b1; ready2 = 1'b1; ready16 = 1'b1;
        mask4 = '0; mask16 = '0;
        drive();

        // T1: reset state, basic 4-way merge, first-write latency
        step();
        chk("t1_rst_wr", wr4, 0);
        chk("t1_rst_data", data4, 0);
        chk("t1_rst_rec", rec4, 0);
        chk("t1_rst_run", run4, 0);
        q4[0] = '{1, 5, 0}; q4[1] = '{2, 6, 0}; q4[2] = '{3, 7, 0}; q4[3] = '{4, 8, 0};
        drive(); step();
        chk("t1_rd_in_rst", last_rd4, 0);
        out4.delete();
        rst4 = 1'b0; drive();
        first = -1;
        for (int c = 1; c <= 40 && out4.size() < 9; c++) begin
            step();
            if (first < 0 && out4.size() > 0) first = c;
        end
        chk("t1_first_wr", first, 2);
        exp_q = '{1, 2, 3, 4, 5, 6, 7, 8, 0};
        chk_seq("t1_seq", out4, exp_q);
        chk("t1_rec", rec4, 8);
        chk("t1_run", run4, 1);

        // T2: L=2 ties go to A, double terminal pops both leaves
        q2[0] = '{3, 3, 0}; q2[1] = '{3, 0};
        rst2 = 1'b0; drive(); h2.delete(); out2.delete();
        for (int c = 0; c < 20 && out2.size() < 4; c++) step();
        exp_q = '{3, 3, 3, 0};
        chk_seq("t2_seq", out2, exp_q);
        chk("t2_npops", h2.size(), 4);
        if (h2.size() == 4) begin
            chk("t2_pop0", h2[0], 1);
            chk("t2_pop1", h2[1], 1);
            chk("t2_pop2", h2[2], 2);
            chk("t2_pop3_both", h2[3], 3);
        end

        // T3: root stalled 20 cycles, lower levels fill then stop
        reset4(); load_long4(); ready4 = 1'b0; drive();
        for (int c = 0; c < 20; c++) step();
        chk("t3_stall_pops", pc4[0] + pc4[1] + pc4[2] + pc4[3], 4);
        chk("t3_stall_rd", last_rd4, 0);
        chk("t3_stall_nwr", out4.size(), 0);
        ready4 = 1'b1; drive();
        for (int c = 0; c < 5; c++) step();
        ready4 = 1'b0; drive();
        for (int c = 0; c < 3; c++) step();
        chk("t3_hold_wr", wr4, 0);
        chk("t3_hold_nout", out4.size(), 5);
        chk("t3_hold_data", data4, 5);
        ready4 = 1'b1; drive();
        drain4(41);
        chk_seq("t3_seq", out4, exp_q);

        // T4: leaf 3 starved, its subtree idle, sibling subtree fills and stalls
        reset4(); load_long4(); mask4 = 4'b1000; drive();
        for (int c = 0; c < 10; c++) step();
        chk("t4_pops23", pc4[2] + pc4[3], 0);
        chk("t4_pops01", pc4[0] + pc4[1], 2);
        chk("t4_nwr", out4.size(), 0);
        mask4 = '0; drive();
        drain4(41);
        chk_seq("t4_seq", out4, exp_q);

        // T5: one-cycle reset mid-stream discards in-flight records
        reset4(); load_long4(); drive();
        for (int c = 0; c < 4; c++) step();
        rst4 = 1'b1; drive(); step();
        chk("t5_rd_in_rst", last_rd4, 0);
        chk("t5_wr", wr4, 0);
        chk("t5_rec", rec4, 0);
        chk("t5_run", run4, 0);
        q4[0] = '{10, 0}; q4[1] = '{20, 0}; q4[2] = '{30, 0}; q4[3] = '{40, 0};
        out4.delete(); rst4 = 1'b0; drive();
        drain4(5);
        exp_q = '{10, 20, 30, 40, 0};
        chk_seq("t5_seq", out4, exp_q);
        chk("t5_rec_new", rec4, 4);
        chk("t5_run_new", run4, 1);

        // T6: L=16 random sorted runs, concurrently L=2 terminal flood to wrap run_count
        nvals = 0;
        for (int r = 0; r < 300; r++) begin
            rb.delete();
            for (int k = 0; k < 16; k++) begin
                int unsigned a, b;
                int n;
                n = $urandom_range(2);
                a = $urandom_range(255, 1);
                b = $urandom_range(255, a);
                if (n >= 1) begin q16[k].push_back(a); rb.push_back(a); end
                if (n >= 2) begin q16[k].push_back(b); rb.push_back(b); end
                q16[k].push_back(0);
            end
            rb.sort();
            nvals += rb.size();
            foreach (rb[i]) exp16.push_back(rb[i]);
            exp16.push_back(0);
        end
        rst2 = 1'b1; term2 = 1'b1; drive(); step();
        n2_wr = 0; out2.delete();
        rst2 = 1'b0; rst16 = 1'b0; rnd16 = 1'b1; drive();
        for (int c = 0; c < 70000 && (term2 || out16.size() < exp16.size()); c++) begin
            step();
            if (term2 && n2_wr >= 65535) begin term2 = 1'b0; drive(); end
            if (rnd16 && out16.size() >= exp16.size()) begin
                rnd16 = 1'b0; ready16 = 1'b1; mask16 = '0; drive();
            end
        end
        step(); step();
        chk("t6_n_terms", n2_wr, 65535);
        chk("t6_run_ffff", run2, 16'hFFFF);
        chk("t6_rec_zero", rec2, 0);
        term2 = 1'b1; drive(); step();
        term2 = 1'b0; drive(); step(); step();
        chk("t6_n_terms_wrap", n2_wr, 65536);
        chk("t6_run_wrap", run2, 0);
        chk_seq("t6_seq16", out16, exp16);
        chk("t6_rec16", rec16, nvals);
        chk("t6_run16", run16, 300);

        chk("rd_while_empty", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/merger_tree_lw.md
MERGER_TREE_LW -- requirements
Module: merger_tree_lw

Interface
REQ-001 The block SHALL have parameter L, default 4: leaf input count; power of two, 2..16.
REQ-002 The block SHALL have parameter W, default 32: record width in bits; all-zero record = run terminal.
REQ-003 The block SHALL have parameter D, default 2: depth of each inter-level FIFO; power of two, >=2.
REQ-004 The block SHALL have port i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 The block SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port i_fifo  input  W*L  leaf head records; leaf k at bits [W*k+W-1:W*k].
REQ-007 The block SHALL have port i_fifo_empty  input  L  leaf k has no valid head when bit k is 1.
REQ-008 The block SHALL have port i_fifo_out_ready  input  1  downstream can accept one record this cycle.
REQ-009 The block SHALL have port o_fifo_read  output  L  combinational pop strobe for leaf k.
REQ-010 The block SHALL have port o_out_fifo_write  output  1  registered write strobe to downstream.
REQ-011 The block SHALL have port o_data  output  W  registered output record, valid when o_out_fifo_write=1.
REQ-012 The block SHALL have port o_rec_count  output  32  count of non-terminal records emitted; wraps.
REQ-013 The block SHALL have port o_run_count  output  16  count of terminals emitted; wraps.

Function
REQ-014 The block SHALL be a binary tree of log2(L) levels of 2-to-1 merge nodes; nodes at the leaf level read leaves 2j and 2j+1; every non-root node writes into its own D-entry FIFO feeding the parent level.
REQ-015 A node SHALL fire in a cycle only when both inputs are non-empty and its output can accept: for non-root nodes, FIFO not full OR parent pops that FIFO this same cycle; for the root, i_fifo_out_ready=1.
REQ-016 On fire with heads A (even input) and B (odd input): a terminal SHALL compare as greater than every non-terminal; if both are non-terminal, the node emits min(A,B) as unsigned and pops only that input; on a tie, it emits A and pops A.
REQ-017 When both heads are terminals, the node SHALL pop both inputs in the same cycle and emit exactly one terminal.
REQ-018 Leaf pops SHALL be combinational: o_fifo_read[k]=1 in exactly the cycle its node consumes leaf k; it SHALL never be asserted while i_fifo_empty[k]=1.
REQ-019 An inter-level FIFO write at cycle t SHALL make the record visible at its head at t+1; a same-cycle push and pop on a full FIFO SHALL be legal and keep occupancy at D.
REQ-020 A root fire at cycle t SHALL drive o_out_fifo_write=1 and o_data=record at t+1; otherwise o_out_fifo_write=0 and o_data holds its last value.
REQ-021 Minimum latency from all leaves non-empty to o_out_fifo_write SHALL be log2(L) cycles (L=2: 1; L=4: 2).
REQ-022 Sustained throughput SHALL be one record per cycle at the root when no input starves and i_fifo_out_ready stays 1.
REQ-023 The counters SHALL increment in the cycle o_out_fifo_write is asserted: o_rec_count for non-terminals, o_run_count for terminals; both wrap modulo 2^width.
REQ-024 i_fifo_out_ready=0 SHALL stall only the root; lower levels SHALL continue until their FIFOs fill; no record is lost or duplicated.

Reset
REQ-025 With i_rst=1 at a clock edge, all FIFOs SHALL become empty, and o_out_fifo_write, o_data, o_rec_count and o_run_count SHALL become 0.
REQ-026 While i_rst=1, o_fifo_read SHALL be all 0; reset mid-stream discards all in-flight records.
REQ-027 Firing SHALL resume on the first cycle after i_rst deasserts.

Verification
REQ-028 The bench SHALL cover: L=4, leaves {1,5,0},{2,6,0},{3,7,0},{4,8,0}, ready=1 -> outputs 1..8 then a single 0; first write at cycle 2; rec_count=8, run_count=1.
REQ-029 The bench SHALL cover: L=2, leaf0={3,3,0}, leaf1={3,0} -> 3(A),3(A),3(B),0; both leaves popped on the terminal cycle.
REQ-030 The bench SHALL cover: L=4 with long runs, ready held 0 for 20 cycles -> leaf pops stop once all FIFOs hold D entries; after release, output continues ascending with no gap or duplicate.
REQ-031 The bench SHALL cover: leaf 3 empty for 10 cycles -> o_fifo_read[2] and o_fifo_read[3] stay 0; other subtrees fill their FIFOs then stall.
REQ-032 The bench SHALL cover: i_rst=1 for one cycle mid-stream -> next cycle write=0, counts=0, FIFOs empty; a new run merges correctly.
REQ-033 The bench SHALL cover: L=16, W=8, 300 random sorted runs -> output sorted per run; counter wraps checked at 2^16 terminals via forced long test.
